// File: rtl/islem_baslatici.sv
// islem_baslatici -- initiator side of the arithmetic-unit handshake.
//
// Takes one request from the calculator control path, puts the operands on
// the unit bus, waits for the unit to accept them (birim_hazir=1 at an edge)
// and then to finish (birim_hazir=1 again), captures the result and reports
// it with a one-cycle cikis_hazir pulse. A cycle counter aborts a transaction
// that runs ZAMAN_ASIMI cycles without completing.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   istek, girdi_a, girdi_b   request strobe and operands (sampled when idle)
//   mesgul                    a request is in flight
//   birim_sayi1/2             operands driven to the unit (held all transaction)
//   birim_hazir/sonuc/gecerli/tasma   unit handshake and result
//   cikis_sonuc/gecerli/tasma captured result (held until next completion)
//   cikis_hazir               one-cycle completion pulse
//   zaman_asimi               last completed request was aborted by timeout
module islem_baslatici #(
  parameter int GENISLIK    = 32,
  parameter int ZAMAN_ASIMI = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    istek,
  input  logic [GENISLIK-1:0]     girdi_a,
  input  logic [GENISLIK-1:0]     girdi_b,
  output logic                    mesgul,
  output logic [GENISLIK-1:0]     birim_sayi1,
  output logic [GENISLIK-1:0]     birim_sayi2,
  input  logic                    birim_hazir,
  input  logic [2*GENISLIK-1:0]   birim_sonuc,
  input  logic                    birim_gecerli,
  input  logic                    birim_tasma,
  output logic [2*GENISLIK-1:0]   cikis_sonuc,
  output logic                    cikis_gecerli,
  output logic                    cikis_tasma,
  output logic                    cikis_hazir,
  output logic                    zaman_asimi
);

  // The counter never needs to hold more than ZAMAN_ASIMI-1.
  localparam int SAY_W = $clog2(ZAMAN_ASIMI);

  typedef enum logic [1:0] {
    BOSTA       = 2'd0,
    KABUL_BEKLE = 2'd1,
    SONUC_BEKLE = 2'd2,
    TAMAM       = 2'd3
  } durum_t;

  durum_t           durum;
  logic [SAY_W-1:0] sayac;
  logic             sure_doldu;

  assign sure_doldu = (sayac == SAY_W'(ZAMAN_ASIMI - 1));
  assign mesgul     = (durum != BOSTA);

  always_ff @(posedge clk) begin
    if (rst) begin
      durum         <= BOSTA;
      sayac         <= '0;
      birim_sayi1   <= '0;
      birim_sayi2   <= '0;
      cikis_sonuc   <= '0;
      cikis_gecerli <= 1'b0;
      cikis_tasma   <= 1'b0;
      cikis_hazir   <= 1'b0;
      zaman_asimi   <= 1'b0;
    end else begin
      cikis_hazir <= 1'b0;
      case (durum)
        BOSTA: begin
          if (istek) begin
            birim_sayi1 <= girdi_a;
            birim_sayi2 <= girdi_b;
            sayac       <= '0;
            durum       <= KABUL_BEKLE;
          end
        end

        // Operands are on the bus; a unit still busy with an older operation
        // keeps hazir low and is simply waited out. Acceptance is not a
        // capture, so an expiring counter aborts even if hazir is high.
        KABUL_BEKLE: begin
          sayac <= sayac + SAY_W'(1);
          if (sure_doldu) begin
            cikis_gecerli <= 1'b0;
            cikis_tasma   <= 1'b0;
            zaman_asimi   <= 1'b1;
            cikis_hazir   <= 1'b1;
            durum         <= TAMAM;
          end else if (birim_hazir) begin
            durum <= SONUC_BEKLE;
          end
        end

        // Capture has priority over a timeout on the same edge.
        SONUC_BEKLE: begin
          sayac <= sayac + SAY_W'(1);
          if (birim_hazir) begin
            cikis_sonuc   <= birim_sonuc;
            cikis_gecerli <= birim_gecerli;
            cikis_tasma   <= birim_tasma;
            zaman_asimi   <= 1'b0;
            cikis_hazir   <= 1'b1;
            durum         <= TAMAM;
          end else if (sure_doldu) begin
            cikis_gecerli <= 1'b0;
            cikis_tasma   <= 1'b0;
            zaman_asimi   <= 1'b1;
            cikis_hazir   <= 1'b1;
            durum         <= TAMAM;
          end
        end

        // cikis_hazir is high during this state only; istek is ignored here.
        TAMAM: begin
          durum <= BOSTA;
        end

        default: durum <= BOSTA;
      endcase
    end
  end

endmodule
